// File: rtl/rk2_rx_sched.sv
// Round-robin scheduler that frames one N-way word source at a time into a shared byte receiver.
// Latency: 6 cycles from req to done (grant, header, high, low, gap, check); each retry adds 7.
// Backpressure: other requesters wait in IDLE while a transfer, including its retries, owns the receiver.
module rk2_rx_sched #(
  parameter int         N         = 4,
  parameter logic [7:0] HEAD      = 8'hCA,
  parameter int         MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [16*N-1:0] data,
  output logic            cs,
  output logic [7:0]      tx_byte,
  input  logic            rx_ack,
  input  logic            rx_err,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [N-1:0]    fail,
  output logic            busy,
  output logic [15:0]     xfer_cnt
);
  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, GAP, CHECK, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] g_idx, g_idx_nxt;
  logic [PW-1:0] pick_idx, cand;
  logic          pick_vld;
  logic [15:0]   word, word_nxt;
  logic [15:0]   xfer_cnt_nxt;
  logic [2:0]    retry, retry_nxt;
  logic          flush_2nd, flush_2nd_nxt;
  logic          rx_ok;

  // First requester strictly after the last one served, wrapping at N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // gnt decodes from state so an async reset drops it without a clock.
  assign busy  = (state != IDLE);
  assign gnt   = busy ? (N'(1) << g_idx) : '0;
  assign rx_ok = !rx_ack && !rx_err;

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    g_idx_nxt     = g_idx;
    word_nxt      = word;
    retry_nxt     = retry;
    flush_2nd_nxt = flush_2nd;
    xfer_cnt_nxt  = xfer_cnt;
    cs            = 1'b1;
    tx_byte       = 8'h00;
    done          = '0;
    fail          = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          g_idx_nxt = pick_idx;
          word_nxt  = data[{pick_idx, 4'b0000} +: 16];
          retry_nxt = 3'd0;
          state_nxt = HDR;
        end
      end
      HDR: begin
        cs        = 1'b0;
        tx_byte   = HEAD;
        state_nxt = HI;
      end
      HI: begin
        cs        = 1'b0;
        tx_byte   = word[15:8];
        state_nxt = LO;
      end
      LO: begin
        cs        = 1'b0;
        tx_byte   = word[7:0];
        state_nxt = GAP;
      end
      GAP: state_nxt = CHECK;
      CHECK: begin
        if (rx_ok) begin
          done         = gnt;
          xfer_cnt_nxt = xfer_cnt + 16'd1;
          ptr_nxt      = g_idx;
          state_nxt    = IDLE;
        end else if (retry < 3'(MAX_RETRY)) begin
          retry_nxt     = retry + 3'd1;
          flush_2nd_nxt = 1'b0;
          state_nxt     = FLUSH;
        end else begin
          fail      = gnt;
          ptr_nxt   = g_idx;
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        // Two idle cycles let the receiver finish its error sequence and re-arm.
        flush_2nd_nxt = 1'b1;
        if (flush_2nd) state_nxt = HDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= PW'(N - 1);
      g_idx     <= '0;
      word      <= 16'h0000;
      retry     <= 3'd0;
      flush_2nd <= 1'b0;
      xfer_cnt  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      g_idx     <= g_idx_nxt;
      word      <= word_nxt;
      retry     <= retry_nxt;
      flush_2nd <= flush_2nd_nxt;
      xfer_cnt  <= xfer_cnt_nxt;
    end
  end

endmodule

// File: doc/rk2_rx_sched.md
Name: rk2_rx_sched

Overview:
- Round-robin scheduler that shares one framed byte receiver among N word sources.
- The receiver accepts a header byte 8'hCA, then a high byte, then a low byte, on input d_in.
  - It holds ack=1 while idle with cs high.
  - It drops ack for one cycle after a good frame.
  - It pulses err for one cycle after a bad header.
- This block picks a requester, serialises its 16-bit word into that frame, and confirms delivery from ack/err.
- On a failed check it retries the same word a bounded number of times.

Parameters:
- N, 4: number of requesters, 2..8.
- HEAD, 8'hCA: frame header byte.
- MAX_RETRY, 2: resend attempts after a failed check, 0..7.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester level request.
- data  in  16*N  word for requester i at data[16*i+15:16*i].
- cs  out  1  receiver select; high = hold receiver idle.
- tx_byte  out  8  byte to receiver d_in.
- rx_ack  in  1  receiver ack.
- rx_err  in  1  receiver err.
- gnt  out  N  one-hot grant, held for the whole transfer including retries.
- done  out  N  one-cycle pulse: word delivered.
- fail  out  N  one-cycle pulse: word dropped after retries are exhausted.
- busy  out  1  high in any state other than IDLE.
- xfer_cnt  out  16  count of delivered words; wraps modulo 2^16.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - cs=1, tx_byte=0, gnt=0, done=0, fail=0, busy=0, xfer_cnt=0.
  - Round-robin pointer goes to N-1, so requester 0 has first priority.
  - Retry count goes to 0.
- Reset mid-transfer aborts the frame without any done or fail pulse.
- States and transitions:
  - IDLE: cs=1, tx_byte=0.
    - If req is non-zero, grant the first set bit searching upward from pointer+1, wrapping at N.
    - Latch that word into a holding register, set gnt, go to HDR.
  - HDR: cs=0, tx_byte=HEAD. Next state HI.
  - HI: cs=0, tx_byte=word[15:8]. Next state LO.
  - LO: cs=0, tx_byte=word[7:0]. Next state GAP.
  - GAP: cs=1, tx_byte=0; covers the receiver's post-frame cycle. Next state CHECK.
  - CHECK: cs=1, sample rx_ack and rx_err.
    - Success (rx_ack=0 and rx_err=0):
      - Pulse done[g] and increment xfer_cnt.
      - Set pointer to g, clear gnt, go to IDLE.
    - Otherwise, if retry count < MAX_RETRY: increment retry count and go to FLUSH.
    - Otherwise: pulse fail[g], set pointer to g, clear gnt, go to IDLE.
  - FLUSH: cs=1 for 2 cycles so the receiver's error sequence completes and it re-arms. Then go to HDR with the same latched word and the same gnt.
- Retry count clears on every IDLE to HDR grant.
- Timing:
  - Best case, req to done pulse is 6 cycles: IDLE grant, HDR, HI, LO, GAP, CHECK.
  - Back-to-back transfers cost 6 cycles per word.
- Handshake:
  - The word is sampled only at grant; later changes to data or req are ignored until done/fail.
  - A requester that keeps req high after done is served again only when its round-robin turn comes.
  - Dropping req while granted does not abort the transfer.
- done and fail are mutually exclusive and never asserted together with a different gnt bit.
- Only one gnt bit is ever set, and only while busy=1.
- If rx_ack and rx_err are both seen in CHECK, treat it as a failure.

Test Plan:
- Reset, then req=4'b0001 with data0=16'h1234:
  - tx_byte sequence over HDR/HI/LO is CA, 12, 34, with cs=0 exactly those 3 cycles.
  - With a behavioural receiver attached, done[0] pulses 6 cycles after req and xfer_cnt=1.
- req=4'b1111 held, receiver always good: grants go 0,1,2,3,0,…, one word every 6 cycles; xfer_cnt=8 after 48 cycles.
- Receiver model forced to hold rx_ack=1 in CHECK, MAX_RETRY=2:
  - Word is framed 3 times, each retry preceded by a 2-cycle FLUSH.
  - Then fail[g] pulses and done never fires; xfer_cnt unchanged.
- Failure on the first attempt, success on the second: exactly one done pulse and no fail; gnt is stable throughout.
- rst=0 asserted during HI:
  - cs=1, gnt=0, busy=0 immediately without waiting for a clock.
  - After release, a new req completes normally.
- Back-to-back traffic: after 65536 delivered words xfer_cnt reads 0; req=4'b0100 granted while data2 changes in HDR still sends the originally latched bytes.
